// File: rtl/dff_response_checker.sv
// Receive-side checker: predicts q_in as d_in delayed LATENCY cycles and tallies matches.
// Optional build macro DFF_CHK_STOP_ON_ERR_EN ends a run at its first mismatch.
module dff_response_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned NUM_CHECKS = 20,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             d_valid_i,
  input  logic [WIDTH-1:0] d_in_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [WIDTH-1:0] first_err_exp_o,
  output logic [WIDTH-1:0] first_err_got_o
);

  localparam int unsigned ChkW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StCheck, StDone} state_e;

  state_e             state_q;
  logic               busy_q, done_q, err_q;
  logic [CNT_W-1:0]   pass_q, fail_q;
  logic [WIDTH-1:0]   exp_q, got_q;
  logic [3:0]         fill_q;
  logic [ChkW-1:0]    chk_q;
  logic [LATENCY-1:0] hv_q;
  logic [WIDTH-1:0]   hd_q [LATENCY];

  logic can_start, cmp_en, cmp_ok, run_end;

  always_comb begin
    can_start = start_i && ((state_q == StIdle) || (state_q == StDone));
    cmp_en    = (state_q == StCheck) && hv_q[LATENCY-1];
    cmp_ok    = (q_in_i == hd_q[LATENCY-1]);
`ifdef DFF_CHK_STOP_ON_ERR_EN
    run_end   = (chk_q == ChkW'(NUM_CHECKS - 1)) || !cmp_ok;
`else
    run_end   = (chk_q == ChkW'(NUM_CHECKS - 1));
`endif
  end

  // History pipe runs in every state so it is already primed when a run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q <= '0;
      for (int i = 0; i < LATENCY; i++) hd_q[i] <= '0;
    end else begin
      hv_q[0] <= d_valid_i;
      hd_q[0] <= d_in_i;
      for (int i = 1; i < LATENCY; i++) begin
        hv_q[i] <= hv_q[i-1];
        hd_q[i] <= hd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      exp_q   <= '0;
      got_q   <= '0;
      fill_q  <= '0;
      chk_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (can_start) begin
            state_q <= StFill;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            exp_q   <= '0;
            got_q   <= '0;
            fill_q  <= 4'(LATENCY);
            chk_q   <= '0;
          end
        end
        StFill: begin
          fill_q <= fill_q - 4'd1;
          if (fill_q == 4'd1) state_q <= StCheck;
        end
        StCheck: begin
          if (cmp_en) begin
            if (cmp_ok) begin
              if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
            end else begin
              if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
              err_q <= 1'b1;
              // Only the first mismatch of a run is kept.
              if (!err_q) begin
                exp_q <= hd_q[LATENCY-1];
                got_q <= q_in_i;
              end
            end
            chk_q <= chk_q + ChkW'(1);
            if (run_end) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign pass_cnt_o      = pass_q;
  assign fail_cnt_o      = fail_q;
  assign first_err_exp_o = exp_q;
  assign first_err_got_o = got_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: three checker instances (1-cycle DUT, 4-bit counters,
// 3-cycle DUT) driven by directed vectors, with a timestamp-based model of the main instance.
module tb_dff_response_checker;

  localparam int unsigned NumChecks = 20;
  localparam int unsigned Lat       = 1;
  localparam int unsigned CntMax    = 16'hFFFF;
`ifdef DFF_CHK_STOP_ON_ERR_EN
  localparam bit StopOnErr = 1'b1;
`else
  localparam bit StopOnErr = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start   = 1'b0;
  logic       d_valid = 1'b0;
  logic       corrupt = 1'b0;
  logic [7:0] d_in    = 8'h00;

  // Stand-in DUTs: ideal DFF with optional bit-0 fault, inverting DFF, 3-stage pipe.
  logic [7:0] q_main = 8'h00;
  logic [7:0] q_sat  = 8'h00;
  logic [7:0] l3_0 = 8'h00, l3_1 = 8'h00, l3_2 = 8'h00;

  logic        busy, done, err;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  fexp, fgot;
  logic        s_busy, s_done, s_err;
  logic [3:0]  s_pass, s_fail;
  logic [7:0]  s_fexp, s_fgot;
  logic        l_busy, l_done, l_err;
  logic [15:0] l_pass, l_fail;
  logic [7:0]  l_fexp, l_fgot;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] vec [20];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_main <= d_in ^ {7'd0, corrupt};
    q_sat  <= ~d_in;
    l3_0   <= d_in;
    l3_1   <= l3_0;
    l3_2   <= l3_1;
  end

  dff_response_checker #(.WIDTH(8), .LATENCY(1), .NUM_CHECKS(20), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .d_valid_i(d_valid), .d_in_i(d_in),
    .q_in_i(q_main), .busy_o(busy), .done_o(done), .err_o(err), .pass_cnt_o(pass_cnt),
    .fail_cnt_o(fail_cnt), .first_err_exp_o(fexp), .first_err_got_o(fgot)
  );

  dff_response_checker #(.WIDTH(8), .LATENCY(1), .NUM_CHECKS(20), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .d_valid_i(d_valid), .d_in_i(d_in),
    .q_in_i(q_sat), .busy_o(s_busy), .done_o(s_done), .err_o(s_err), .pass_cnt_o(s_pass),
    .fail_cnt_o(s_fail), .first_err_exp_o(s_fexp), .first_err_got_o(s_fgot)
  );

  dff_response_checker #(.WIDTH(8), .LATENCY(3), .NUM_CHECKS(20), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .d_valid_i(d_valid), .d_in_i(d_in),
    .q_in_i(l3_2), .busy_o(l_busy), .done_o(l_done), .err_o(l_err), .pass_cnt_o(l_pass),
    .fail_cnt_o(l_fail), .first_err_exp_o(l_fexp), .first_err_got_o(l_fgot)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model of the main instance: a run starts at edge s, compares the sample taken Lat edges
  // earlier from edge s+Lat+1 on, and ends once NumChecks comparisons have been made.
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } smp_t;

  smp_t        hist[$];
  bit          m_run, m_done, m_err;
  int unsigned m_pass, m_fail, m_ncmp, m_edge, m_arm;
  logic [7:0]  m_exp, m_got;

  task automatic model_reset();
    hist.delete();
    m_run = 0; m_done = 0; m_err = 0;
    m_pass = 0; m_fail = 0; m_ncmp = 0; m_edge = 0; m_arm = 0;
    m_exp = 8'h00; m_got = 8'h00;
  endtask

  initial begin : model
    smp_t tail;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_edge++;
        tail = (hist.size() == Lat) ? hist[0] : '0;
        if (m_run && (m_edge >= m_arm) && tail.v) begin
          if (q_main == tail.d) begin
            if (m_pass < CntMax) m_pass++;
          end else begin
            if (!m_err) begin
              m_exp = tail.d;
              m_got = q_main;
            end
            m_err = 1;
            if (m_fail < CntMax) m_fail++;
          end
          m_ncmp++;
          if ((m_ncmp == NumChecks) || (StopOnErr && m_err)) begin
            m_run  = 0;
            m_done = 1;
          end
        end else if (!m_run && start) begin
          m_run = 1; m_done = 0; m_err = 0;
          m_pass = 0; m_fail = 0; m_ncmp = 0;
          m_exp = 8'h00; m_got = 8'h00;
          m_arm = m_edge + Lat + 1;
        end
        hist.push_back('{v: d_valid, d: d_in});
        if (hist.size() > Lat) void'(hist.pop_front());
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("pass_cnt", 32'(pass_cnt), m_pass);
      chk("fail_cnt", 32'(fail_cnt), m_fail);
      chk("first_err_exp", 32'(fexp), 32'(m_exp));
      chk("first_err_got", 32'(fgot), 32'(m_got));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'd0);
    chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    chk({tag, "_sat_fail"}, 32'(s_fail), 32'd0);
    chk({tag, "_l3_pass"}, 32'(l_pass), 32'd0);
  endtask

  // One run: start pulse, then the 20 table vectors (optionally 1,0 valid pattern).
  task automatic run(input bit gaps, input bit inject, input int start_at, input int rst_at);
    start = 1'b1; d_valid = 1'b0; corrupt = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d_valid = 1'b1;
      d_in    = vec[k];
      corrupt = inject && (k == 2 || k == 6);
      start   = (k == start_at);
      tick();
      start   = 1'b0;
      corrupt = 1'b0;
      if (k == rst_at) begin
        d_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (gaps) begin
        d_valid = 1'b0;
        tick();
      end
    end
    d_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(done && s_done && l_done) && n < 80) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_l3_done"}, 32'(l_done), 32'd1);
  endtask

  initial begin : stim
    vec = '{8'h3C, 8'h81, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h3D, 8'h66, 8'h99, 8'h12,
            8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFF, 8'h00, 8'h7E, 8'hC3};

    // Reset held while stimulus and start pulses toggle.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_valid = 1'b1;
      d_in    = 8'h55 + 8'(i);
      start   = i[0];
      tick();
    end
    start = 1'b0; d_valid = 1'b0;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Clean run, plus saturation and 3-cycle latency on the side instances.
    run(1'b0, 1'b0, -1, -1);
    wait_done("clean");
    chk("clean_pass", 32'(pass_cnt), 32'd20);
    chk("clean_fail", 32'(fail_cnt), 32'd0);
    chk("clean_err", 32'(err), 32'd0);
    chk("clean_busy", 32'(busy), 32'd0);
    chk("sat_fail", 32'(s_fail), StopOnErr ? 32'd1 : 32'hF);
    chk("sat_pass", 32'(s_pass), 32'd0);
    chk("sat_err", 32'(s_err), 32'd1);
    chk("l3_pass", 32'(l_pass), 32'd20);
    chk("l3_fail", 32'(l_fail), 32'd0);
    repeat (3) tick();
    chk("done_held", 32'(done), 32'd1);

    // Bit-0 faults on the 3rd and 7th responses.
    run(1'b0, 1'b1, -1, -1);
    wait_done("fault");
    chk("fault_pass", 32'(pass_cnt), StopOnErr ? 32'd2 : 32'd18);
    chk("fault_fail", 32'(fail_cnt), StopOnErr ? 32'd1 : 32'd2);
    chk("fault_err", 32'(err), 32'd1);
    chk("fault_exp", 32'(fexp), 32'hA5);
    chk("fault_got", 32'(fgot), 32'hA4);

    // Valid every other cycle.
    run(1'b1, 1'b0, -1, -1);
    wait_done("gaps");
    chk("gaps_pass", 32'(pass_cnt), 32'd20);
    chk("gaps_fail", 32'(fail_cnt), 32'd0);

    // Start while busy is ignored.
    run(1'b0, 1'b0, 5, -1);
    wait_done("midstart");
    chk("midstart_pass", 32'(pass_cnt), 32'd20);

    // Reset mid-run, then a fresh run.
    run(1'b0, 1'b0, -1, 10);
    chk_all_zero("postrst");
    run(1'b0, 1'b0, -1, -1);
    wait_done("fresh");
    chk("fresh_pass", 32'(pass_cnt), 32'd20);
    chk("fresh_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
